// File: rtl/demux1_7_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : demux1_7_buf_if
// Purpose  : Producer/consumer handshake bundle for the 1-to-7 distributor.
// Revision : 1.0
// ============================================================================
interface demux1_7_buf_if #(
    parameter int DATA_W = 32
);
    logic [2:0]          sel_in;
    logic [DATA_W-1:0]   data_in;
    logic                in_valid;
    logic                in_ready;
    logic [7*DATA_W-1:0] data_out;
    logic [6:0]          out_valid;
    logic [6:0]          out_ready;

    modport master (
        output sel_in, data_in, in_valid, out_ready,
        input  in_ready, data_out, out_valid
    );

    modport slave (
        input  sel_in, data_in, in_valid, out_ready,
        output in_ready, data_out, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/demux1_7_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux1_7_buf
// Purpose  : Registered 1-to-7 word distributor, one holding slot per channel.
// Revision : 1.0
// ============================================================================
module demux1_7_buf #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    demux1_7_buf_if.slave    bus,
    output logic             bad_sel_pulse,
    output logic             bad_sel_sticky,
    output logic [CNT_W-1:0] xfer_count
);
    localparam logic [2:0] c_sel_bad = 3'd7;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              r_state   [7];
    state_t              w_state_nxt [7];
    logic [DATA_W-1:0]   r_data    [7];
    logic [6:0]          w_full;
    logic [6:0]          w_acc;
    logic [6:0]          w_drain;
    logic [7:0]          w_full8;
    logic [7:0]          w_rdy8;
    logic                w_in_ready;
    logic                w_accept;
    logic [2:0]          w_pop;
    logic [7*DATA_W-1:0] w_data_out;

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            w_full[i] = (r_state[i] == FULL);
        end
    end

    // Pad to 8 entries so sel_in==7 indexes a harmless zero instead of out of range.
    assign w_full8    = {1'b0, w_full};
    assign w_rdy8     = {1'b0, bus.out_ready};
    assign w_in_ready = (bus.sel_in == c_sel_bad) | ~w_full8[bus.sel_in] | w_rdy8[bus.sel_in];
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_drain    = w_full & bus.out_ready;

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            w_acc[i] = w_accept & (bus.sel_in == 3'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                r_state[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // A new word wins over a drain, so drain+fill in one cycle keeps the slot FULL.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                EMPTY:   if (w_acc[i]) w_state_nxt[i] = FULL;
                FULL:    if (!w_acc[i] && w_drain[i]) w_state_nxt[i] = EMPTY;
                default: w_state_nxt[i] = EMPTY;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < 7; g++) begin : g_ch
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_data[g] <= '0;
                end else if (w_acc[g]) begin
                    r_data[g] <= bus.data_in;
                end
            end
        end
    endgenerate

    always_comb begin
        w_data_out = '0;
        for (int i = 0; i < 7; i++) begin
            w_data_out[i*DATA_W +: DATA_W] = r_data[i];
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 7; i++) begin
            w_pop = w_pop + {2'b00, w_drain[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bad_sel_pulse  <= 1'b0;
            bad_sel_sticky <= 1'b0;
            xfer_count     <= '0;
        end else begin
            bad_sel_pulse  <= w_accept & (bus.sel_in == c_sel_bad);
            bad_sel_sticky <= bad_sel_sticky | (w_accept & (bus.sel_in == c_sel_bad));
            xfer_count     <= xfer_count + CNT_W'(w_pop);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_full;
    assign bus.data_out  = w_data_out;

endmodule
`default_nettype wire

// File: tb/tb_demux1_7_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux1_7_buf
// Purpose  : Directed self-checking bench for the 1-to-7 distributor.
// Revision : 1.0
// ============================================================================
module tb_demux1_7_buf;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic             clk;
    logic             reset;
    logic             bad_sel_pulse;
    logic             bad_sel_sticky;
    logic [CNT_W-1:0] xfer_count;

    int checks;
    int failures;
    logic [CNT_W-1:0]    exp_cnt;
    logic [DATA_W-1:0]   exp_data [7];
    logic [7*DATA_W-1:0] exp_bus;

    demux1_7_buf_if #(.DATA_W(DATA_W)) bus ();

    demux1_7_buf #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .bad_sel_pulse  (bad_sel_pulse),
        .bad_sel_sticky (bad_sel_sticky),
        .xfer_count     (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7*DATA_W-1:0] pack_exp();
        logic [7*DATA_W-1:0] v;
        for (int i = 0; i < 7; i++) v[i*DATA_W +: DATA_W] = exp_data[i];
        return v;
    endfunction

    task automatic test_reset();
        checks++; if (bus.out_valid !== 7'h00) begin failures++; $display("FAIL rst_valid: got %b expected %b", bus.out_valid, 7'h00); end
        checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL rst_data: got %h expected 0", bus.data_out); end
        checks++; if (xfer_count !== 16'h0000) begin failures++; $display("FAIL rst_count: got %h expected 0000", xfer_count); end
        checks++; if (bad_sel_pulse !== 1'b0 || bad_sel_sticky !== 1'b0) begin failures++; $display("FAIL rst_bad: got %b%b expected 00", bad_sel_pulse, bad_sel_sticky); end
        for (int s = 0; s < 8; s++) begin
            bus.sel_in = 3'(s);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready sel=%0d: got %b expected 1", s, bus.in_ready); end
        end
    endtask

    task automatic test_single();
        bus.sel_in = 3'd3; bus.data_in = 32'hDEADBEEF; bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL single_ready: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0; exp_data[3] = 32'hDEADBEEF;
        checks++; if (bus.out_valid !== 7'b0001000) begin failures++; $display("FAIL single_valid: got %b expected 0001000", bus.out_valid); end
        checks++; if (bus.data_out[3*DATA_W +: DATA_W] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data: got %h expected deadbeef", bus.data_out[3*DATA_W +: DATA_W]); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.out_valid !== 7'b0001000 || bus.data_out[3*DATA_W +: DATA_W] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold%0d: got %b/%h expected 0001000/deadbeef", k, bus.out_valid, bus.data_out[3*DATA_W +: DATA_W]); end
        end
        bus.out_ready = 7'b0001000;
        tick();
        bus.out_ready = 7'b0; exp_cnt = exp_cnt + 16'd1;
        checks++; if (bus.out_valid !== 7'b0) begin failures++; $display("FAIL single_drain: got %b expected 0000000", bus.out_valid); end
        checks++; if (xfer_count !== exp_cnt) begin failures++; $display("FAIL single_count: got %h expected %h", xfer_count, exp_cnt); end
        checks++; if (bus.data_out[3*DATA_W +: DATA_W] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_keep: got %h expected deadbeef", bus.data_out[3*DATA_W +: DATA_W]); end
    endtask

    task automatic test_backpressure();
        bus.sel_in = 3'd5; bus.data_in = 32'hA5A5A5A5; bus.in_valid = 1'b1;
        tick();
        exp_data[5] = 32'hA5A5A5A5;
        bus.data_in = 32'h00000055;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready5: got %b expected 0", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 7'b0100000 || bus.data_out[5*DATA_W +: DATA_W] !== 32'hA5A5A5A5) begin failures++; $display("FAIL bp_hold5: got %b/%h expected 0100000/a5a5a5a5", bus.out_valid, bus.data_out[5*DATA_W +: DATA_W]); end
        bus.sel_in = 3'd2; bus.data_in = 32'h00002222;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready2: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0; exp_data[2] = 32'h00002222; exp_bus = pack_exp();
        checks++; if (bus.out_valid !== 7'b0100100) begin failures++; $display("FAIL bp_valid: got %b expected 0100100", bus.out_valid); end
        checks++; if (bus.data_out !== exp_bus) begin failures++; $display("FAIL bp_data: got %h expected %h", bus.data_out, exp_bus); end
        bus.out_ready = 7'b0100100;
        tick();
        bus.out_ready = 7'b0; exp_cnt = exp_cnt + 16'd2;
        checks++; if (bus.out_valid !== 7'b0 || xfer_count !== exp_cnt) begin failures++; $display("FAIL bp_drain: got %b/%h expected 0000000/%h", bus.out_valid, xfer_count, exp_cnt); end
    endtask

    task automatic test_drain_fill();
        bus.sel_in = 3'd0; bus.data_in = 32'h11; bus.in_valid = 1'b1;
        tick();
        bus.data_in = 32'h22; bus.out_ready = 7'b0000001;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL df_ready: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 7'b0; exp_cnt = exp_cnt + 16'd1; exp_data[0] = 32'h22;
        checks++; if (bus.out_valid !== 7'b0000001) begin failures++; $display("FAIL df_valid: got %b expected 0000001", bus.out_valid); end
        checks++; if (bus.data_out[DATA_W-1:0] !== 32'h22) begin failures++; $display("FAIL df_data: got %h expected 00000022", bus.data_out[DATA_W-1:0]); end
        checks++; if (xfer_count !== exp_cnt) begin failures++; $display("FAIL df_count: got %h expected %h", xfer_count, exp_cnt); end
        bus.out_ready = 7'b0000001;
        tick();
        bus.out_ready = 7'b0; exp_cnt = exp_cnt + 16'd1;
        checks++; if (bus.out_valid !== 7'b0 || xfer_count !== exp_cnt) begin failures++; $display("FAIL df_drain: got %b/%h expected 0000000/%h", bus.out_valid, xfer_count, exp_cnt); end
    endtask

    task automatic test_bad_sel();
        bus.sel_in = 3'd7; bus.data_in = 32'hFFFF0000; bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bad_ready: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0; exp_bus = pack_exp();
        checks++; if (bad_sel_pulse !== 1'b1 || bad_sel_sticky !== 1'b1) begin failures++; $display("FAIL bad_pulse_on: got %b%b expected 11", bad_sel_pulse, bad_sel_sticky); end
        checks++; if (bus.out_valid !== 7'b0 || bus.data_out !== exp_bus) begin failures++; $display("FAIL bad_no_write: got %b/%h expected 0000000/%h", bus.out_valid, bus.data_out, exp_bus); end
        tick();
        checks++; if (bad_sel_pulse !== 1'b0 || bad_sel_sticky !== 1'b1) begin failures++; $display("FAIL bad_pulse_off: got %b%b expected 01", bad_sel_pulse, bad_sel_sticky); end
        checks++; if (xfer_count !== exp_cnt) begin failures++; $display("FAIL bad_count: got %h expected %h", xfer_count, exp_cnt); end
    endtask

    task automatic test_wrap();
        int k_total;
        k_total = int'(16'hFFFE - exp_cnt);
        bus.sel_in = 3'd0; bus.in_valid = 1'b1; bus.out_ready = 7'b0000001;
        for (int k = 0; k < k_total; k++) begin
            bus.data_in = 32'(k);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 7'b0; exp_cnt = 16'hFFFE; exp_data[0] = 32'(k_total - 1);
        checks++; if (xfer_count !== exp_cnt) begin failures++; $display("FAIL wrap_pre: got %h expected %h", xfer_count, exp_cnt); end
        checks++; if (bus.data_out[DATA_W-1:0] !== exp_data[0]) begin failures++; $display("FAIL wrap_last0: got %h expected %h", bus.data_out[DATA_W-1:0], exp_data[0]); end
        bus.in_valid = 1'b1;
        bus.sel_in = 3'd1; bus.data_in = 32'h101; tick();
        bus.sel_in = 3'd2; bus.data_in = 32'h202; tick();
        bus.sel_in = 3'd4; bus.data_in = 32'h404; tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 7'b0010110 || xfer_count !== 16'hFFFE) begin failures++; $display("FAIL wrap_fill: got %b/%h expected 0010110/fffe", bus.out_valid, xfer_count); end
        bus.out_ready = 7'b0010110;
        tick();
        bus.out_ready = 7'b0; exp_cnt = 16'h0001;
        checks++; if (xfer_count !== exp_cnt) begin failures++; $display("FAIL wrap_count: got %h expected %h", xfer_count, exp_cnt); end
        checks++; if (bus.out_valid !== 7'b0 || bad_sel_sticky !== 1'b1) begin failures++; $display("FAIL wrap_after: got %b/%b expected 0000000/1", bus.out_valid, bad_sel_sticky); end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.sel_in = 3'd6; bus.data_in = 32'h66666666; tick();
        bus.sel_in = 3'd3; bus.data_in = 32'h33333333; tick();
        bus.sel_in = 3'd4; bus.data_in = 32'h44444444;
        checks++; if (bus.out_valid !== 7'b1001000) begin failures++; $display("FAIL mid_pre: got %b expected 1001000", bus.out_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 7'b0 || bus.data_out !== '0) begin failures++; $display("FAIL mid_async: got %b/%h expected 0000000/0", bus.out_valid, bus.data_out); end
        checks++; if (xfer_count !== 16'h0 || bad_sel_sticky !== 1'b0 || bad_sel_pulse !== 1'b0) begin failures++; $display("FAIL mid_status: got %h/%b%b expected 0000/00", xfer_count, bad_sel_pulse, bad_sel_sticky); end
        tick();
        checks++; if (bus.out_valid !== 7'b0) begin failures++; $display("FAIL mid_held: got %b expected 0000000", bus.out_valid); end
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 7'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_release: got %b/%b expected 0000000/1", bus.out_valid, bus.in_ready); end
    endtask

    initial begin
        checks = 0; failures = 0; exp_cnt = '0;
        for (int i = 0; i < 7; i++) exp_data[i] = '0;
        reset = 1'b1;
        bus.sel_in = 3'd0; bus.data_in = '0; bus.in_valid = 1'b0; bus.out_ready = 7'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        test_reset();
        test_single();
        test_backpressure();
        test_drain_fill();
        test_bad_sel();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
